// File: rtl/wfq_pifo_pkg.sv
// Shared WFQ entry layout and epoch-relative sort key helpers.
// Entry layout from MSB to LSB is {valid, overflow, round, addr}.
package wfq_pifo_pkg;

  localparam int PIFO_WIDTH_DEF          = 32;
  localparam int PIFO_OVERFLOW_WIDTH_DEF = 1;
  localparam int PIFO_ROUND_WIDTH_DEF    = 18;
  localparam int PIFO_ADDR_WIDTH_DEF     = 12;
  localparam int KEY_WIDTH               = PIFO_OVERFLOW_WIDTH_DEF + PIFO_ROUND_WIDTH_DEF;

  typedef logic [KEY_WIDTH-1:0] pifo_key_t;

  // XOR against the last dequeued epoch so the current epoch sorts first.
  function automatic pifo_key_t make_key(
    input logic [PIFO_OVERFLOW_WIDTH_DEF-1:0] ovf,
    input logic [PIFO_ROUND_WIDTH_DEF-1:0]    round,
    input logic [PIFO_OVERFLOW_WIDTH_DEF-1:0] last_ovf
  );
    return {ovf ^ last_ovf, round};
  endfunction

  function automatic logic key_le(input pifo_key_t a, input pifo_key_t b);
    return a <= b;
  endfunction

endpackage

// File: rtl/wfq_pifo_sorter_if.sv
// Enqueue/dequeue handshake between the rank engine, the PIFO and the scheduler.
interface wfq_pifo_sorter_if #(
  parameter int PIFO_WIDTH = 32
);
  logic                  enq_valid;
  logic [PIFO_WIDTH-1:0] enq_data;
  logic                  deq_req;
  logic                  deq_valid;
  logic [PIFO_WIDTH-1:0] deq_data;

  modport master (output enq_valid, enq_data, deq_req, input deq_valid, deq_data);
  modport slave  (input enq_valid, enq_data, deq_req, output deq_valid, deq_data);
endinterface

// File: rtl/wfq_pifo_slot.sv
// One PIFO slot: entry register plus "my key is greater than the new key" flag.
module wfq_pifo_slot
  import wfq_pifo_pkg::*;
#(
  parameter int PIFO_WIDTH          = PIFO_WIDTH_DEF,
  parameter int PIFO_OVERFLOW_WIDTH = PIFO_OVERFLOW_WIDTH_DEF,
  parameter int PIFO_ROUND_WIDTH    = PIFO_ROUND_WIDTH_DEF,
  parameter int PIFO_ADDR_WIDTH     = PIFO_ADDR_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PIFO_WIDTH-1:0]          prev_data,
  input  logic [PIFO_WIDTH-1:0]          next_data,
  input  logic [PIFO_WIDTH-1:0]          new_data,
  input  logic                           shift_up,
  input  logic                           shift_down,
  input  logic                           insert_here,
  input  pifo_key_t                      new_key,
  input  logic [PIFO_OVERFLOW_WIDTH-1:0] last_ovf,
  output logic [PIFO_WIDTH-1:0]          data,
  output logic                           gt
);

  pifo_key_t slot_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (insert_here) begin
      data <= new_data;
    end else if (shift_up) begin
      data <= next_data;
    end else if (shift_down) begin
      data <= prev_data;
    end
  end

  assign slot_key = make_key(data[PIFO_ADDR_WIDTH+PIFO_ROUND_WIDTH +: PIFO_OVERFLOW_WIDTH],
                             data[PIFO_ADDR_WIDTH +: PIFO_ROUND_WIDTH], last_ovf);
  assign gt = data[PIFO_WIDTH-1] && !key_le(slot_key, new_key);

endmodule

// File: rtl/wfq_pifo_sorter.sv
// Shift-register PIFO ordered by epoch-relative rank; slot 0 is the head.
// Feeds the last dequeued rank back to the rank engine.
module wfq_pifo_sorter
  import wfq_pifo_pkg::*;
#(
  parameter int DEPTH               = 16,
  parameter int PIFO_WIDTH          = PIFO_WIDTH_DEF,
  parameter int PIFO_OVERFLOW_WIDTH = PIFO_OVERFLOW_WIDTH_DEF,
  parameter int PIFO_ROUND_WIDTH    = PIFO_ROUND_WIDTH_DEF,
  parameter int PIFO_ADDR_WIDTH     = PIFO_ADDR_WIDTH_DEF,
  parameter int DROP_CNT_WIDTH      = 16,
  localparam int CNT_W              = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  wfq_pifo_sorter_if.slave               pif,
  output logic                           last_pifo_valid,
  output logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow,
  output logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round,
  output logic [CNT_W-1:0]               count,
  output logic                           full,
  output logic                           empty,
  output logic [DROP_CNT_WIDTH-1:0]      drop_count
);

  localparam int OVF_LSB   = PIFO_ADDR_WIDTH + PIFO_ROUND_WIDTH;
  localparam int ROUND_LSB = PIFO_ADDR_WIDTH;

  logic [PIFO_WIDTH-1:0] slot_data [DEPTH];
  logic [PIFO_WIDTH-1:0] prev_in   [DEPTH];
  logic [PIFO_WIDTH-1:0] next_in   [DEPTH];
  logic [DEPTH-1:0]      gt;
  logic [DEPTH-1:0]      gt_eff;
  logic [CNT_W-1:0]      ins;
  logic [CNT_W-1:0]      count_nxt;
  pifo_key_t             new_key;
  logic                  deq_eff;
  logic                  enq_req;
  logic                  enq_accept;
  logic                  enq_drop;
  logic                  deq_valid_q;
  logic [PIFO_WIDTH-1:0] deq_data_q;

  assign deq_eff    = pif.deq_req && (count != '0);
  assign enq_req    = pif.enq_valid && pif.enq_data[PIFO_WIDTH-1];
  assign enq_accept = enq_req && ((count < CNT_W'(DEPTH)) || deq_eff);
  assign enq_drop   = enq_req && !enq_accept;
  assign new_key    = make_key(pif.enq_data[OVF_LSB +: PIFO_OVERFLOW_WIDTH],
                               pif.enq_data[ROUND_LSB +: PIFO_ROUND_WIDTH],
                               last_pifo_overflow);

  // With a concurrent dequeue the insert point is found in the shifted-up view.
  always_comb begin
    gt_eff = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      gt_eff[i] = deq_eff ? gt[i+1] : gt[i];
    end
    gt_eff[DEPTH-1] = deq_eff ? 1'b0 : gt[DEPTH-1];
  end

  always_comb begin
    ins = deq_eff ? (count - CNT_W'(1)) : count;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (gt_eff[i]) ins = CNT_W'(i);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam logic [CNT_W-1:0] IDX = CNT_W'(i);

    if (i == 0) begin : g_first
      assign prev_in[i] = '0;
    end else begin : g_prev
      assign prev_in[i] = slot_data[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign next_in[i] = '0;
    end else begin : g_next
      assign next_in[i] = slot_data[i+1];
    end

    wfq_pifo_slot #(
      .PIFO_WIDTH          (PIFO_WIDTH),
      .PIFO_OVERFLOW_WIDTH (PIFO_OVERFLOW_WIDTH),
      .PIFO_ROUND_WIDTH    (PIFO_ROUND_WIDTH),
      .PIFO_ADDR_WIDTH     (PIFO_ADDR_WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .prev_data   (prev_in[i]),
      .next_data   (next_in[i]),
      .new_data    (pif.enq_data),
      .shift_up    (deq_eff && (!enq_accept || (IDX < ins))),
      .shift_down  (enq_accept && !deq_eff && (IDX > ins)),
      .insert_here (enq_accept && (IDX == ins)),
      .new_key     (new_key),
      .last_ovf    (last_pifo_overflow),
      .data        (slot_data[i]),
      .gt          (gt[i])
    );
  end

  always_comb begin
    count_nxt = count;
    if (enq_accept && !deq_eff) count_nxt = count + CNT_W'(1);
    else if (!enq_accept && deq_eff) count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count              <= '0;
      full               <= 1'b0;
      empty              <= 1'b1;
      deq_valid_q        <= 1'b0;
      deq_data_q         <= '0;
      last_pifo_valid    <= 1'b0;
      last_pifo_overflow <= '0;
      last_pifo_round    <= '0;
      drop_count         <= '0;
    end else begin
      count       <= count_nxt;
      full        <= (count_nxt == CNT_W'(DEPTH));
      empty       <= (count_nxt == '0);
      deq_valid_q <= deq_eff;
      deq_data_q  <= deq_eff ? slot_data[0] : '0;
      if (deq_eff) begin
        last_pifo_valid    <= 1'b1;
        last_pifo_overflow <= slot_data[0][OVF_LSB +: PIFO_OVERFLOW_WIDTH];
        last_pifo_round    <= slot_data[0][ROUND_LSB +: PIFO_ROUND_WIDTH];
      end
      if (enq_drop && (drop_count != '1)) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
    end
  end

  assign pif.deq_valid = deq_valid_q;
  assign pif.deq_data  = deq_data_q;

endmodule

// File: tb/tb_wfq_pifo_sorter.sv
// Directed bench for wfq_pifo_sorter with hand-computed expectations.
module tb_wfq_pifo_sorter;

  logic        clk = 1'b0;
  logic        rst;
  logic        last_pifo_valid;
  logic [0:0]  last_pifo_overflow;
  logic [17:0] last_pifo_round;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] drop_count;
  int          checks = 0;
  int          errors = 0;

  wfq_pifo_sorter_if #(.PIFO_WIDTH(32)) pif ();

  wfq_pifo_sorter dut (
    .clk                (clk),
    .rst                (rst),
    .pif                (pif),
    .last_pifo_valid    (last_pifo_valid),
    .last_pifo_overflow (last_pifo_overflow),
    .last_pifo_round    (last_pifo_round),
    .count              (count),
    .full               (full),
    .empty              (empty),
    .drop_count         (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ent(input logic ovf, input int round, input int addr);
    logic [17:0] r;
    logic [11:0] a;
    r = 18'(round);
    a = 12'(addr);
    return {1'b1, ovf, r, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] d);
    pif.enq_valid = 1'b1;
    pif.enq_data  = d;
    step();
    pif.enq_valid = 1'b0;
    pif.enq_data  = '0;
  endtask

  task automatic deq_chk(input string tag, input logic [31:0] exp);
    pif.deq_req = 1'b1;
    step();
    pif.deq_req = 1'b0;
    chk({tag, "_valid"}, 32'(pif.deq_valid), 32'd1);
    chk({tag, "_data"}, pif.deq_data, exp);
  endtask

  initial begin
    rst           = 1'b1;
    pif.enq_valid = 1'b0;
    pif.enq_data  = '0;
    pif.deq_req   = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_deq_valid", 32'(pif.deq_valid), 32'd0);
    chk("rst_deq_data", pif.deq_data, 32'd0);
    chk("rst_last_valid", 32'(last_pifo_valid), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // rank order
    enq(ent(0, 30, 1));
    enq(ent(0, 10, 2));
    enq(ent(0, 20, 3));
    chk("ord_count", 32'(count), 32'd3);
    deq_chk("ord_deq0", ent(0, 10, 2));
    chk("ord_last0", 32'(last_pifo_round), 32'd10);
    chk("ord_last_valid", 32'(last_pifo_valid), 32'd1);
    step();
    chk("ord_pulse0", 32'(pif.deq_valid), 32'd0);
    deq_chk("ord_deq1", ent(0, 20, 3));
    chk("ord_last1", 32'(last_pifo_round), 32'd20);
    step();
    chk("ord_pulse1", 32'(pif.deq_valid), 32'd0);
    deq_chk("ord_deq2", ent(0, 30, 1));
    chk("ord_last2", 32'(last_pifo_round), 32'd30);
    chk("ord_empty", 32'(empty), 32'd1);

    // FIFO among equal ranks, back-to-back dequeues
    enq(ent(0, 5, 7));
    enq(ent(0, 5, 8));
    enq(ent(0, 5, 9));
    deq_chk("tie_deq0", ent(0, 5, 7));
    deq_chk("tie_deq1", ent(0, 5, 8));
    deq_chk("tie_deq2", ent(0, 5, 9));

    // next-epoch entry sorts after a large current-epoch round
    enq(ent(1, 2, 4));
    enq(ent(0, 262000, 5));
    deq_chk("ep_deq0", ent(0, 262000, 5));
    chk("ep_last_ovf0", 32'(last_pifo_overflow), 32'd0);
    deq_chk("ep_deq1", ent(1, 2, 4));
    chk("ep_last_ovf1", 32'(last_pifo_overflow), 32'd1);
    chk("ep_last_round1", 32'(last_pifo_round), 32'd2);

    // entry with valid flag clear is ignored and not counted as a drop
    pif.enq_valid = 1'b1;
    pif.enq_data  = 32'h0000_0123;
    step();
    pif.enq_valid = 1'b0;
    chk("inv_count", 32'(count), 32'd0);
    chk("inv_drop", 32'(drop_count), 32'd0);

    // fill, overflow drop, then enqueue with dequeue while full
    for (int i = 0; i < 16; i++) enq(ent(1, 100 + i, i));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    enq(ent(1, 50, 99));
    chk("drop_count", 32'(drop_count), 32'd1);
    chk("drop_cnt_hold", 32'(count), 32'd16);
    chk("drop_full", 32'(full), 32'd1);
    pif.enq_valid = 1'b1;
    pif.enq_data  = ent(1, 200, 85);
    deq_chk("full_swap_deq", ent(1, 100, 0));
    pif.enq_valid = 1'b0;
    chk("full_swap_count", 32'(count), 32'd16);
    for (int k = 0; k < 15; k++) deq_chk("drain", ent(1, 101 + k, 1 + k));
    deq_chk("drain_tail", ent(1, 200, 85));
    chk("drain_empty", 32'(empty), 32'd1);

    // no bypass: dequeue on empty with concurrent enqueue
    pif.enq_valid = 1'b1;
    pif.enq_data  = ent(1, 4, 68);
    pif.deq_req   = 1'b1;
    step();
    pif.enq_valid = 1'b0;
    pif.deq_req   = 1'b0;
    chk("nobyp_valid", 32'(pif.deq_valid), 32'd0);
    chk("nobyp_count", 32'(count), 32'd1);
    deq_chk("nobyp_deq", ent(1, 4, 68));

    // asynchronous reset mid-stream
    for (int i = 1; i <= 4; i++) enq(ent(1, i, i));
    pif.enq_valid = 1'b1;
    pif.enq_data  = ent(1, 5, 5);
    pif.deq_req   = 1'b1;
    step();
    pif.enq_valid = 1'b0;
    pif.deq_req   = 1'b0;
    chk("pre_rst_valid", 32'(pif.deq_valid), 32'd1);
    chk("pre_rst_count", 32'(count), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_last_valid", 32'(last_pifo_valid), 32'd0);
    chk("arst_deq_valid", 32'(pif.deq_valid), 32'd0);
    chk("arst_drop", 32'(drop_count), 32'd0);
    step();
    rst = 1'b0;
    pif.deq_req = 1'b1;
    step();
    pif.deq_req = 1'b0;
    chk("post_rst_deq", 32'(pif.deq_valid), 32'd0);
    step();
    chk("post_rst_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wfq_pifo_sorter.md
Name: wfq_pifo_sorter

Overview:
- Shift-register PIFO that accepts ranked entries from the WFQ rank engine and keeps them sorted by wrap-aware rank.
- Returns the minimum-rank entry on dequeue.
- Feeds the rank of the last dequeued entry back to the rank engine (last_pifo_valid/overflow/round), closing the virtual-time loop.
- Sits between the rank calculator and the output-queue scheduler.

Parameters:
- DEPTH, 16, number of entry slots (power of two, 2..64).
- PIFO_WIDTH, 32, entry width: {valid[1], overflow, round, addr}.
- PIFO_OVERFLOW_WIDTH, 1, epoch (overflow) field width.
- PIFO_ROUND_WIDTH, 18, round field width.
- PIFO_ADDR_WIDTH, 12, packet-address field width.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- enq_valid  in  1  entry present this cycle; no backpressure upstream.
- enq_data  in  PIFO_WIDTH  ranked entry; bit[PIFO_WIDTH-1] is the entry-valid flag.
- deq_req  in  1  request to pop the head.
- deq_valid  out  1  deq_data valid, one-cycle pulse.
- deq_data  out  PIFO_WIDTH  popped entry.
- last_pifo_valid  out  1  at least one dequeue has occurred since reset.
- last_pifo_overflow  out  PIFO_OVERFLOW_WIDTH  epoch of the last dequeued entry.
- last_pifo_round  out  PIFO_ROUND_WIDTH  round of the last dequeued entry.
- count  out  log2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- drop_count  out  DROP_CNT_WIDTH  dropped enqueues, saturating.

Behaviour:
- Reset (async, rst=1): all slots invalid; count=0; empty=1; full=0; deq_valid=0; deq_data=0; last_pifo_valid=0; last_pifo_overflow=0; last_pifo_round=0; drop_count=0. Reset mid-operation discards all stored entries immediately.
- Sort key: {ovf XOR last_pifo_overflow, round}, compared unsigned. The current epoch sorts before the next epoch. With a 1-bit epoch, ranks more than one epoch ahead alias; the rank engine guarantees this never happens.
- Ordering: slot 0 is the head (minimum key).
  - A new entry is inserted after all entries with key <= its key, so equal ranks leave in FIFO order.
  - Slots at and after the insert point shift down by one.
- Enqueue effective when enq_valid=1, enq_data MSB=1, and (count<DEPTH or a dequeue is effective in the same cycle).
  - enq_valid with MSB=0: ignored, not counted as a drop.
  - enq_valid with MSB=1 and no space: entry dropped, drop_count += 1, saturating at all-ones.
- Dequeue effective when deq_req=1 and count>0.
  - Next cycle: deq_valid=1, deq_data = the old slot 0.
  - On the same edge: last_pifo_valid=1, last_pifo_overflow/round = that entry's fields.
  - last_pifo_* holds until the next dequeue.
- deq_req with count=0: deq_valid=0 next cycle, no state change. There is no bypass; an entry enqueued in the same cycle is not dequeued.
- Simultaneous enqueue and dequeue:
  - The dequeue removes the current head.
  - Insertion position is computed against the array after the shift-up, with keys using the pre-update last_pifo_overflow.
  - count unchanged.
  - Accepted even when full.
- Latency:
  - An accepted entry is visible at the head the cycle after acceptance.
  - Dequeue latency is 1 cycle.
  - Throughput is one enqueue plus one dequeue per cycle.
- count/full/empty are registered and reflect state after the last edge.
- Arithmetic: count moves by +1, -1, or 0; it never exceeds DEPTH or goes below 0.

Decomposition:
- Shared package wfq_pifo_pkg: entry field widths and bit offsets (valid, overflow, round, addr), and a key-extract/compare function (epoch-relative key build, "less-or-equal" predicate). The rank engine reuses the same field layout.
- One natural sub-module, wfq_pifo_slot: one slot register plus its comparator, with inputs for the previous slot's data, the next slot's data, the new entry, the shift-up/shift-down/insert-here controls, and the local greater-than flag.
- Top level:
  - DEPTH slot instances.
  - Priority encoder finding the first slot whose key is greater than the new key.
  - Occupancy, drop counter, and feedback registers.

Test Plan:
- Reset then enqueue rounds 30, 10, 20 (ovf=0, addr=1,2,3) on consecutive cycles, then 3 dequeues -> addr 2,3,1 in that order; last_pifo_round sequence 10, 20, 30; deq_valid exactly 1 cycle after each deq_req.
- Enqueue three entries with round=5 and addr 7, 8, 9 -> dequeue order 7, 8, 9 (FIFO among ties).
- last_pifo_overflow=0; enqueue {ovf=1, round=2} then {ovf=0, round=262000}; dequeue twice -> round 262000 first, then the ovf=1 entry; after the second dequeue last_pifo_overflow=1.
- Fill to DEPTH=16 and enqueue one more -> full=1, drop_count=1, count stays 16. Next cycle, enqueue plus deq_req together -> accepted, count=16, head removed.
- Empty PIFO, deq_req with enq round 4 in the same cycle -> deq_valid=0, count=1. The following deq_req returns round 4.
- Enqueue 5 entries, assert rst mid-stream asynchronously between edges -> count=0, empty=1, last_pifo_valid=0, deq_valid=0 immediately. A subsequent deq_req produces no deq_valid.
